uart_tx: RTL

- UART transmitter: serialises one 8-bit byte per frame onto the `tx` line in 8N1 format, LSB first.
- Directly upstream of the UART receive stage; `tx` connects straight to that stage's `rx` input, board-level or in loopback.
- Uses the same `clk_freq`/`baud_rate` bit timing as the receiver, so one parameter set drives both ends.
- Byte-level valid/ready handshake towards the host logic.

---
 rtl/uart_tx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 serial framing, LSB first, byte-level valid/ready handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int clk_freq  = 50000000,
    parameter int baud_rate = 19200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data_in,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy
);

    localparam int          clock_divide = clk_freq / baud_rate;
    localparam logic [11:0] last_cnt     = 12'(clock_divide - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    state_t      state_r;
    state_t      state_nxt_s;
    logic [11:0] cnt_r;
    logic [11:0] cnt_nxt_s;
    logic [2:0]  idx_r;
    logic [2:0]  idx_nxt_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_nxt_s;
    logic        tx_r;
    logic        tx_nxt_s;
    logic        bit_end_s;
    logic        accept_s;

    assign tx_ready = (state_r == ST_IDLE) && !rst;
    assign tx_busy  = (state_r != ST_IDLE);
    assign tx       = tx_r;
    assign accept_s = tx_valid && tx_ready;

    // Next-state, bit-period counter, bit index and next line level.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + 12'd1;
        idx_nxt_s   = idx_r;
        shift_nxt_s = shift_r;
        bit_end_s   = (cnt_r == last_cnt);
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 12'd0;
                idx_nxt_s = 3'd0;
                if (accept_s) begin
                    state_nxt_s = ST_START;
                    shift_nxt_s = tx_data_in;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_DATA;
                    cnt_nxt_s   = 12'd0;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_nxt_s = 12'd0;
                    // index wraps back to 0 as the last data bit is left
                    idx_nxt_s = idx_r + 3'd1;
                    if (idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt_s = ST_PARITY;
`else
                        state_nxt_s = ST_STOP;
`endif
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_STOP;
                    cnt_nxt_s   = 12'd0;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 12'd0;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 12'd0;
                idx_nxt_s   = 3'd0;
            end
        endcase

        // line level is derived from the state being entered so tx stays a plain flop
        case (state_nxt_s)
            ST_IDLE:   tx_nxt_s = 1'b1;
            ST_START:  tx_nxt_s = 1'b0;
            ST_DATA:   tx_nxt_s = shift_nxt_s[idx_nxt_s];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_nxt_s = even_parity(shift_nxt_s);
`endif
            ST_STOP:   tx_nxt_s = 1'b1;
            default:   tx_nxt_s = 1'b1;
        endcase
    end

    // State, counter, index, shift register and registered line output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 12'd0;
            idx_r   <= 3'd0;
            shift_r <= 8'd0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            shift_r <= shift_nxt_s;
            tx_r    <= tx_nxt_s;
        end
    end

endmodule
